// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags -- single-clock FIFO with status flags.
//
// Stores up to DEPTH words of WIDTH bits. A write is accepted when the FIFO
// is not full and a read is accepted when it is not empty. Full and empty
// are judged on the registered count, so a full FIFO refuses a write even
// when a read is accepted in the same cycle, and an empty FIFO refuses a read
// even when a write is accepted in the same cycle.
//
// Parameters:
//   WIDTH    data word width in bits (>=1)
//   DEPTH    number of storage words (power of two, >=2)
//   FWFT     0 = registered read, 1 = first-word-fall-through
//   AF_LEVEL almost_full asserts when count >= AF_LEVEL
//   AE_LEVEL almost_empty asserts when count <= AE_LEVEL
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   wr_en        write request
//   data_in      write data
//   rd_en        read request
//   data_out     read data (FWFT=0: loaded on accepted read; FWFT=1: head word)
//   valid        FIFO holds at least one word
//   ready        FIFO holds fewer than DEPTH words
//   almost_full  count >= AF_LEVEL
//   almost_empty count <= AE_LEVEL
//   count        words currently stored, 0..DEPTH
//   overflow     one-cycle pulse after a refused write
//   underflow    one-cycle pulse after a refused read
module sync_fifo_flags #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           data_out,
  output logic                       valid,
  output logic                       ready,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             wr_acc;
  logic             rd_acc;

  // Flags derive from the registered count only, which is what rules out
  // both the full bypass and the empty bypass.
  assign count        = count_q;
  assign ready        = (count_q != CW'(DEPTH));
  assign valid        = (count_q != '0);
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));

  assign wr_acc = wr_en && ready;
  assign rd_acc = rd_en && valid;

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && !ready;
      underflow <= rd_en && !valid;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; a word is only ever read after it
  // has been written, so clearing it would buy nothing and blocks RAM mapping.
  // Writes are still gated by rst so a reset cycle stores nothing.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_ptr] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is visible combinationally; meaningful only while valid=1.
      assign data_out = mem[rd_ptr];
    end else begin : g_reg_read
      logic [WIDTH-1:0] dout_q;
      always_ff @(posedge clk) begin
        if (rst)         dout_q <= '0;
        else if (rd_acc) dout_q <= mem[rd_ptr];
      end
      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Testbench for sync_fifo_flags: one registered-read and one FWFT instance
// driven by the same stimulus, both compared against a queue-based model.
module tb_sync_fifo_flags;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] data_in = '0;

  logic [WIDTH-1:0] d0_data_out, d1_data_out;
  logic             d0_valid, d1_valid, d0_ready, d1_ready;
  logic             d0_af, d1_af, d0_ae, d1_ae;
  logic [CW-1:0]    d0_count, d1_count;
  logic             d0_ov, d1_ov, d0_un, d1_un;

  sync_fifo_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_reg (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(d0_data_out), .valid(d0_valid), .ready(d0_ready),
    .almost_full(d0_af), .almost_empty(d0_ae), .count(d0_count),
    .overflow(d0_ov), .underflow(d0_un)
  );

  sync_fifo_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(d1_data_out), .valid(d1_valid), .ready(d1_ready),
    .almost_full(d1_af), .almost_empty(d1_ae), .count(d1_count),
    .overflow(d1_ov), .underflow(d1_un)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, act, exp);
    end
  endtask

  // Reference model: contents as a plain queue plus the registered read word
  // and the two refusal pulses.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] dout_m = '0;
  bit               ov_m = 0;
  bit               un_m = 0;

  task automatic check_all();
    int n;
    n = q.size();
    check("count_reg",  32'(d0_count), n);
    check("count_fwft", 32'(d1_count), n);
    check("valid_reg",  32'(d0_valid), 32'(n != 0));
    check("valid_fwft", 32'(d1_valid), 32'(n != 0));
    check("ready_reg",  32'(d0_ready), 32'(n != DEPTH));
    check("ready_fwft", 32'(d1_ready), 32'(n != DEPTH));
    check("af_reg",     32'(d0_af), 32'(n >= AF));
    check("af_fwft",    32'(d1_af), 32'(n >= AF));
    check("ae_reg",     32'(d0_ae), 32'(n <= AE));
    check("ae_fwft",    32'(d1_ae), 32'(n <= AE));
    check("ovf_reg",    32'(d0_ov), 32'(ov_m));
    check("ovf_fwft",   32'(d1_ov), 32'(ov_m));
    check("unf_reg",    32'(d0_un), 32'(un_m));
    check("unf_fwft",   32'(d1_un), 32'(un_m));
    check("dout_reg",   32'(d0_data_out), 32'(dout_m));
    if (n != 0) check("dout_fwft", 32'(d1_data_out), 32'(q[0]));
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, then
  // compare all outputs 1 time unit after the edge.
  task automatic step(input bit w, input logic [WIDTH-1:0] d, input bit r, input bit rs);
    bit full, empty;
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    rst     = rs;
    @(posedge clk);
    if (rs) begin
      q.delete();
      dout_m = '0;
      ov_m   = 0;
      un_m   = 0;
    end else begin
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      ov_m  = w && full;
      un_m  = r && empty;
      if (r && !empty) dout_m = q.pop_front();
      if (w && !full) q.push_back(d);
    end
    #1;
    check_all();
  endtask

  initial begin
    // Reset state.
    step(0, 8'h00, 0, 1);

    // Fill with 0x01..0x08, then a refused 0xFF write.
    for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 0);
    step(1, 8'hFF, 0, 0);
    step(0, 8'h00, 0, 0);

    // Drain in order, then one refused read; data_out must hold 0x08.
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);

    // Hold count at 4 with simultaneous read/write across pointer wraps.
    for (int i = 0; i < 4; i++) step(1, 8'(8'h10 + i), 0, 0);
    for (int i = 0; i < 20; i++) step(1, 8'(8'h20 + i), 1, 0);

    // Full FIFO with both enables: read accepted, write refused.
    for (int i = 0; i < 4; i++) step(1, 8'(8'h40 + i), 0, 0);
    step(1, 8'hEE, 1, 0);
    step(0, 8'h00, 0, 0);

    // Empty FIFO with both enables: write accepted, read refused.
    for (int i = 0; i < 7; i++) step(0, 8'h00, 1, 0);
    step(1, 8'h5A, 1, 0);
    step(0, 8'h00, 1, 0);

    // Write 0xA5 into empty FIFO: FWFT head visible next cycle, then read.
    step(1, 8'hA5, 0, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 1, 0);

    // Reset at count=5 with a concurrent write; nothing may be stored.
    for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 0, 0);
    step(1, 8'h77, 0, 1);
    step(1, 8'h33, 0, 0);
    step(0, 8'h00, 1, 0);

    // Randomized traffic in epochs biased toward filling or draining.
    for (int e = 0; e < 40; e++) begin
      int wp;
      int rp;
      wp = (e % 2 == 0) ? 75 : 30;
      rp = (e % 2 == 0) ? 30 : 75;
      for (int i = 0; i < 50; i++) begin
        step($urandom_range(99) < wp, 8'($urandom), $urandom_range(99) < rp,
             $urandom_range(199) == 0);
      end
    end

    wr_en = 0;
    rd_en = 0;
    rst   = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, number of storage words (power of two, >=2).
REQ-003 SHALL have parameter FWFT, default 0: 0 = registered read, 1 = first-word-fall-through.
REQ-004 SHALL have parameter AF_LEVEL, default DEPTH-2, almost-full threshold in words.
REQ-005 SHALL have parameter AE_LEVEL, default 1, almost-empty threshold in words.
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-007 SHALL have port rst  input  1  reset; one clock, synchronous, active-high.
REQ-008 SHALL have port wr_en  input  1  write request.
REQ-009 SHALL have port data_in  input  WIDTH  write data.
REQ-010 SHALL have port rd_en  input  1  read request.
REQ-011 SHALL have port data_out  output  WIDTH  read data.
REQ-012 SHALL have port valid  output  1  FIFO holds >=1 word (read will be accepted).
REQ-013 SHALL have port ready  output  1  FIFO holds <DEPTH words (write will be accepted).
REQ-014 SHALL have port almost_full  output  1  count >= AF_LEVEL.
REQ-015 SHALL have port almost_empty  output  1  count <= AE_LEVEL.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  words currently stored, 0..DEPTH.
REQ-017 SHALL have port overflow  output  1  one-cycle pulse: write refused.
REQ-018 SHALL have port underflow  output  1  one-cycle pulse: read refused.

Function
REQ-019 Write SHALL be accepted iff wr_en && ready; data_in stored at write pointer, pointer advances by 1, wraps DEPTH-1 -> 0.
REQ-020 Read SHALL be accepted iff rd_en && valid; read pointer advances by 1, wraps DEPTH-1 -> 0.
REQ-021 ready SHALL equal (count != DEPTH); valid SHALL equal (count != 0); both combinational from registered count.
REQ-022 count SHALL update at the edge: +1 write only, -1 read only, unchanged for both or neither; never exceeds DEPTH or goes below 0.
REQ-023 Full FIFO: write SHALL be refused even if a read is accepted in the same cycle (no full bypass).
REQ-024 Empty FIFO: read SHALL be refused even if a write is accepted in the same cycle (no empty bypass).
REQ-025 FWFT=0: on accepted read, data_out SHALL load the head word at that edge (visible next cycle) and hold otherwise.
REQ-026 FWFT=1: data_out SHALL present the head word whenever valid=1, with 1-cycle latency from write into empty FIFO to valid=1; value is don't-care when valid=0.
REQ-027 almost_full and almost_empty SHALL be combinational compares of count against AF_LEVEL / AE_LEVEL.
REQ-028 overflow SHALL be registered: high for exactly the cycle after any cycle with wr_en && !ready.
REQ-029 underflow SHALL be registered: high for exactly the cycle after any cycle with rd_en && !valid.
REQ-030 Refused operations SHALL change no pointer, count, memory or data_out.
REQ-031 Storage array SHALL not require reset; contents are unreadable until written.

Reset
REQ-032 rst=1 at an edge SHALL set pointers=0, count=0, overflow=0, underflow=0, and (FWFT=0) data_out=0.
REQ-033 After reset: valid=0, ready=1, almost_empty=1, almost_full=0 (AF_LEVEL>0).
REQ-034 rst SHALL take priority over wr_en/rd_en; reset mid-operation discards all stored words.

Verification (WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1 unless noted)
REQ-035 Write 0x01..0x08 then 9th write 0xFF -> count=8, ready=0, almost_full=1, overflow pulses 1 cycle, 0xFF not stored.
REQ-036 FWFT=0, from full read 8 times -> data_out 0x01..0x08 each one cycle after its read, count=0, valid=0, almost_empty=1; extra read -> underflow 1-cycle pulse, data_out holds 0x08.
REQ-037 Hold count=4, assert wr_en and rd_en 20 cycles with incrementing data -> count stays 4, pointers wrap, data_out sequence in write order.
REQ-038 Full FIFO, wr_en=rd_en=1 -> read accepted, write refused, overflow pulses, count=7.
REQ-039 FWFT=1, write 0xA5 into empty -> valid=1 and data_out=0xA5 next cycle without rd_en; rd_en -> valid=0 next cycle.
REQ-040 count=5, assert rst one cycle with wr_en=1 -> count=0, valid=0, ready=1, data_out=0 (FWFT=0), nothing written.
